player_anim_sequencer: RTL
==========================

# player_anim_sequencer

Animation controller for the player sprite. It decides which animation (idle, run, prone, aim-up, diagonal run, jump, death) owns the player sprite ROM and which frame of that animation is shown, advancing frames from the vertical frame tick. It sits between `playerMovement` / keyboard decode and the per-animation address generators, replacing keycode-driven selection with a registered state machine. Its outputs drive the address/playerOn mux select and each generator's frame index.

## Interface
- `FRAME_DIV`, 4: frame ticks per animation step (≥1)
- `RUN_FRAMES`, 6: run-cycle length (≤8)
- `DIAG_FRAMES`, 3: diagonal-run cycle length (≤8)
- `JUMP_STEPS`, 8: steps a jump lasts; frame index wraps 0..3 within it
- `DEAD_FRAMES`, 5: death animation length (≤8)

Ports:
- `Clk` in 1: system clock
- `Reset` in 1: synchronous, active-high
- `frame_clk` in 1: ~60 Hz level from VGA; treated as asynchronous, rising edge = tick
- `keycode` in 5: [0] left, [1] right, [2] up, [3] down, [4] jump
- `keyPress` in 1: keycode valid
- `gameState` in 2: only `GS_PLAY` (2'b01) advances anything
- `playerMoving` in 1: from `playerMovement`
- `direction` in 1: 1 = right, 0 = left
- `playerHit` in 1: level, collision with hazard
- `animSel` out 3: `anim_t` code
- `frameIdx` out 3: frame within animation
- `facing` out 1: latched direction
- `jumping` out 1: high while in JUMP
- `animDone` out 1: one-cycle pulse when death animation completes

## Operation
- States (`anim_t`): IDLE=0, RUN=1, DOWN=2, UP=3, RUN_UP=4, RUN_DOWN=5, JUMP=6, DEAD=7. `animSel` is the state register.
- Reset values: `animSel`=IDLE, `frameIdx`=0, `facing`=1, `jumping`=0, `animDone`=0; tick divider = 0.
- When `gameState` ≠ `GS_PLAY`: state, divider, `frameIdx` and `facing` hold. Ticks are discarded, not queued.
- Transition priority, evaluated each cycle in play:
  1. `playerHit` and state≠DEAD → DEAD.
  2. `keyPress` and `keycode[4]` and state ∉ {JUMP, DEAD} → JUMP.
  3. In JUMP: stay until `JUMP_STEPS` steps elapse, then take the ground decision.
  4. DEAD is absorbing until `Reset`.
  5. Ground decision, evaluated for all other states:
     - moving & up → RUN_UP
     - moving & down → RUN_DOWN
     - moving → RUN
     - !moving & down → DOWN
     - !moving & up → UP
     - otherwise → IDLE
     - Key bits count only when `keyPress`=1.
- Step: the tick divider counts ticks 0..`FRAME_DIV`-1; a step occurs on a tick where the divider wraps.
- Frame index per state, on step:
  - RUN: wraps 0..`RUN_FRAMES`-1.
  - RUN_UP/RUN_DOWN: wraps 0..`DIAG_FRAMES`-1.
  - JUMP: (index+1) mod 4; a step counter counts to `JUMP_STEPS`.
  - DEAD: increments to `DEAD_FRAMES`-1 and saturates. `animDone` pulses on the step that reaches `DEAD_FRAMES`-1.
  - IDLE/DOWN/UP: index stays 0.
- Any state change clears `frameIdx`, the divider and the jump step counter in the same cycle. A state change outranks a coincident step.
- `facing` ← `direction` every play cycle except in DEAD, where it freezes.
- `jumping` = (state==JUMP), registered together with the state.

## Timing
- All outputs are registered. No combinational input→output path.
- State change: inputs sampled at edge N, new `animSel` visible after edge N, with `frameIdx`=0 at that same edge.
- Tick path: 2-flop synchronizer plus edge register. Effective tick = 3 `Clk` edges after the `frame_clk` rise. `frameIdx` updates on that edge when the tick is a step.
- `animDone` is high for exactly one cycle, on the same edge that `frameIdx` becomes `DEAD_FRAMES`-1.
- `Reset` mid-animation (including DEAD and JUMP) returns all outputs to reset values at the next edge and clears the synchronizer.

## Structure
- Package `player_anim_pkg` holds:
  - `anim_t` enum (3-bit)
  - `GS_PLAY` constant
  - key bit indices `KEY_LEFT`, `KEY_RIGHT`, `KEY_UP`, `KEY_DOWN`, `KEY_JUMP`
- Sub-module `frame_tick_sync` (`Clk`, `Reset`, `frame_clk` → one-cycle `tick`) holds the synchronizer and rising-edge detector.
- Top level holds the FSM, tick divider, frame counter and jump step counter.

## Test plan
- Reset, play, `FRAME_DIV`=4, no keys, 10 ticks → `animSel`=0 and `frameIdx`=0 throughout; `facing`=1.
- `playerMoving`=1, 26 ticks → `animSel`=1; `frameIdx` steps every 4th tick 0,1,2,3,4,5,0; first step appears 3 clocks after the 4th `frame_clk` rise.
- In RUN at `frameIdx`=3, assert `keyPress` with `keycode`=5'b10000 → `animSel`=6, `frameIdx`=0, `jumping`=1. After 8 steps, with `playerMoving`=1 and up held → `animSel`=4.
- `playerHit` and jump key asserted in the same cycle → `animSel`=7. After 4 steps `frameIdx`=4 with a single-cycle `animDone`. Further ticks hold 4, keys are ignored, `facing` stays frozen.
- `gameState`=2'b10 during RUN, 12 ticks → `frameIdx` and `animSel` unchanged. Return to play → counting resumes from the held divider value.
- `Reset` asserted while in DEAD at `frameIdx`=2 → next edge: `animSel`=0, `frameIdx`=0, `facing`=1, `animDone`=0.

Source files
------------

// File: rtl/player_anim_pkg.sv
// Shared types and constants for the player sprite animation sequencer.
package player_anim_pkg;

    typedef enum logic [2:0] {
        AnimIdle    = 3'd0,
        AnimRun     = 3'd1,
        AnimDown    = 3'd2,
        AnimUp      = 3'd3,
        AnimRunUp   = 3'd4,
        AnimRunDown = 3'd5,
        AnimJump    = 3'd6,
        AnimDead    = 3'd7
    } anim_t;

    localparam logic [1:0] GS_PLAY = 2'b01;

    localparam int unsigned KEY_LEFT  = 0;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_DOWN  = 3;
    localparam int unsigned KEY_JUMP  = 4;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous VGA frame level into the Clk domain and emits a
// one-cycle tick on each rising edge (visible for the third Clk edge after the rise).
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/player_anim_sequencer.sv
// Player sprite animation FSM: picks the active animation and advances its
// frame index from the divided vertical frame tick.
module player_anim_sequencer
    import player_anim_pkg::*;
#(
    parameter int unsigned FRAME_DIV   = 4,
    parameter int unsigned RUN_FRAMES  = 6,
    parameter int unsigned DIAG_FRAMES = 3,
    parameter int unsigned JUMP_STEPS  = 8,
    parameter int unsigned DEAD_FRAMES = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [4:0] keycode,
    input  logic       keyPress,
    input  logic [1:0] gameState,
    input  logic       playerMoving,
    input  logic       direction,
    input  logic       playerHit,
    output logic [2:0] animSel,
    output logic [2:0] frameIdx,
    output logic       facing,
    output logic       jumping,
    output logic       animDone
);

    localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned JstW = $clog2(JUMP_STEPS + 1);

    anim_t            r_state, w_state_d, w_ground;
    logic [DivW-1:0]  r_div, w_div_d;
    logic [2:0]       r_idx, w_idx_d;
    logic [JstW-1:0]  r_jst, w_jst_d;
    logic             r_facing, w_facing_d;
    logic             r_jumping;
    logic             r_done, w_done_d;
    logic             w_tick, w_play, w_up, w_down, w_jump_key, w_div_wrap, w_step;
    logic             w_unused_lr;

    frame_tick_sync u_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    assign w_unused_lr = keycode[KEY_LEFT] ^ keycode[KEY_RIGHT];
    assign w_play      = (gameState == GS_PLAY);
    assign w_up        = keyPress & keycode[KEY_UP];
    assign w_down      = keyPress & keycode[KEY_DOWN];
    assign w_jump_key  = keyPress & keycode[KEY_JUMP];
    assign w_div_wrap  = (r_div == DivW'(FRAME_DIV - 1));
    assign w_step      = w_tick & w_div_wrap;

    always_comb begin
        w_ground = AnimIdle;
        if (playerMoving) begin
            w_ground = w_up ? AnimRunUp : (w_down ? AnimRunDown : AnimRun);
        end else begin
            w_ground = w_down ? AnimDown : (w_up ? AnimUp : AnimIdle);
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_div_d    = r_div;
        w_idx_d    = r_idx;
        w_jst_d    = r_jst;
        w_facing_d = r_facing;
        w_done_d   = 1'b0;
        if (w_play) begin
            if (r_state != AnimDead) begin
                w_facing_d = direction;
            end
            if (playerHit && r_state != AnimDead) begin
                w_state_d = AnimDead;
            end else if (w_jump_key && r_state != AnimJump && r_state != AnimDead) begin
                w_state_d = AnimJump;
            end else if (r_state == AnimJump) begin
                if (w_step && r_jst == JstW'(JUMP_STEPS - 1)) begin
                    w_state_d = w_ground;
                end
            end else if (r_state != AnimDead) begin
                w_state_d = w_ground;
            end

            // A state change discards any coincident step.
            if (w_state_d != r_state) begin
                w_div_d = '0;
                w_idx_d = '0;
                w_jst_d = '0;
            end else if (w_tick) begin
                w_div_d = w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) begin
                    case (r_state)
                        AnimRun: begin
                            w_idx_d = (r_idx == 3'(RUN_FRAMES - 1)) ? 3'd0 : r_idx + 3'd1;
                        end
                        AnimRunUp, AnimRunDown: begin
                            w_idx_d = (r_idx == 3'(DIAG_FRAMES - 1)) ? 3'd0 : r_idx + 3'd1;
                        end
                        AnimJump: begin
                            w_idx_d = {1'b0, r_idx[1:0] + 2'd1};
                            w_jst_d = r_jst + 1'b1;
                        end
                        AnimDead: begin
                            if (r_idx < 3'(DEAD_FRAMES - 1)) begin
                                w_idx_d  = r_idx + 3'd1;
                                w_done_d = (w_idx_d == 3'(DEAD_FRAMES - 1));
                            end
                        end
                        default: w_idx_d = 3'd0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= AnimIdle;
            r_div     <= '0;
            r_idx     <= '0;
            r_jst     <= '0;
            r_facing  <= 1'b1;
            r_jumping <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_div     <= w_div_d;
            r_idx     <= w_idx_d;
            r_jst     <= w_jst_d;
            r_facing  <= w_facing_d;
            r_jumping <= (w_state_d == AnimJump);
            r_done    <= w_done_d;
        end
    end

    assign animSel  = r_state;
    assign frameIdx = r_idx;
    assign facing   = r_facing;
    assign jumping  = r_jumping;
    assign animDone = r_done;

endmodule
